hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// Pipeline hazard and stall controller for the 5-stage MIPS core. Generates forwarding selects,
// load-use and branch-compare stalls, E-stage flush, and sequences the variable-latency data
// memory via a req/ack handshake, freezing F..M while an M-stage access is pending.
// Also keeps a saturating stall-cycle counter and a sticky memory-timeout error.
// PARAMETERS
// TIMEOUT   64  max WAIT cycles before dmem access is declared failed (>=2)
// CNT_W     16  width of stall-cycle counter
// PORTS
// clk         in   1      core clock, rising edge
// reset       in   1      asynchronous, active-low reset
// rsD,rtD     in   5      source regs, decode stage
// rsE,rtE     in   5      source regs, execute stage
// writeregE/M/W in 5      destination reg, E/M/W stage
// regwriteE/M/W in 1      destination write enable, E/M/W stage
// memtoregE/M in   1      load in E/M stage
// memwriteM   in   1      store in M stage
// branchD     in   1      branch in decode stage
// dmem_ack    in   1      data memory completes access this cycle
// cnt_clr     in   1      synchronous clear of stall counter
// stallF,stallD out 1     hold PC / IF-ID register
// flushE      out  1      clear ID-EX register (bubble)
// stallE,stallM out 1     hold ID-EX / EX-MEM registers
// flushW      out  1      clear MEM-WB register (bubble)
// forwardAD,forwardBD out 1  forward ALUOutM to decode comparator operand A/B
// forwardAE,forwardBE out 2  00 regfile, 01 resultW, 10 ALUOutM
// dmem_req    out  1      data memory access request
// mem_err     out  1      sticky timeout flag
// stall_cnt   out  CNT_W  count of cycles with stallF=1, saturating
// BEHAVIOUR
// - Forwarding, combinational: forwardAE=10 if rsE!=0 & rsE==writeregM & regwriteM; else 01 if
//   rsE!=0 & rsE==writeregW & regwriteW; else 00. M priority over W. BE identical on rtE.
//   forwardAD = rsD!=0 & rsD==writeregM & regwriteM; forwardBD likewise on rtD. Reg 0 never forwarded.
// - lwstall = memtoregE & (rtE==rsD | rtE==rtD).
// - brstall = branchD & ((regwriteE & (writeregE==rsD|writeregE==rtD)) |
//   (memtoregM & (writeregM==rsD|writeregM==rtD))).
// - access = memtoregM | memwriteM. FSM states IDLE, WAIT, DONE, ERR (reset -> IDLE):
//   IDLE: access -> WAIT. WAIT: ack -> DONE; wait count reaches TIMEOUT -> ERR.
//   DONE -> IDLE unconditionally (the access instruction leaves M this cycle).
//   ERR: absorbing until reset; mem_err=1.
//   memstall = access & (state==IDLE | state==WAIT) | state==ERR. dmem_req=1 iff memstall & ~ERR.
//   Minimum cost: 2 stall cycles per access (IDLE, WAIT with immediate ack), then DONE.
//   ack in IDLE or DONE is ignored. Wait counter clears on entering WAIT.
// - stallF=stallD = lwstall | brstall | memstall. stallE=stallM=flushW = memstall.
//   flushE = (lwstall | brstall) & ~memstall (E held, not bubbled, during memstall).
// - stall_cnt: +1 each cycle stallF=1, saturates at all-ones; cnt_clr wins over increment.
// - Reset (any time, incl. mid-WAIT): state IDLE, dmem_req=0, mem_err=0, stall_cnt=0 asynchronously;
//   all other outputs are combinational and follow inputs with state=IDLE.
// - Latency: all stall/forward outputs combinational same cycle; FSM/counter update on clk rise.
// STRUCTURE
// - mips_pipe_pkg: enum hz_state_t {IDLE,WAIT,DONE,ERR}; localparams FWD_RF=2'b00,
//   FWD_W=2'b01, FWD_M=2'b10.
// - One sub-module: hazard_mem_fsm (state, wait counter, timeout, dmem_req, memstall, mem_err).
//   Forward/stall equations and stall counter stay in hazard_ctrl.
// TESTING
// 1 add $3 in M (regwriteM=1,writeregM=3) and W, rsE=3 -> forwardAE=10; M idle -> 01; rsE=0 -> 00.
// 2 lw $5 in E, rtD=5 -> stallF=stallD=flushE=1 one cycle; next cycle lw in M, no lwstall.
// 3 beq with rsD=7, writeregE=7 regwriteE=1 -> stall+flushE; then memtoregM & writeregM=7 -> stall again.
// 4 lw in M, ack 3 cycles after req -> dmem_req high 4 cycles, stallE=stallM=flushW high same 4, DONE
//   cycle all low; stall_cnt increments 4.
// 5 lw in M, ack never, TIMEOUT=4 -> ERR, mem_err=1 held, dmem_req=0, stalls held; reset clears all.
// 6 reset asserted mid-WAIT -> dmem_req drops without clk; stall_cnt=0; lwstall during memstall -> flushE=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and forwarding encodings for the MIPS pipeline hazard logic.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // M stage wins over W so the youngest producer supplies the operand; $0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic [4:0] dstM,
        input logic       wrM,
        input logic [4:0] dstW,
        input logic       wrW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if ((src != 5'd0) && (src == dstM) && wrM) begin
            sel = FWD_M;
        end else if ((src != 5'd0) && (src == dstW) && wrW) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory handshake sequencer: raises dmem_req and holds the pipe until ack,
// or latches a permanent error once the access has waited TIMEOUT cycles.
module hazard_mem_fsm
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic access,
    input  logic dmemAck,
    output logic memStall,
    output logic dmemReq,
    output logic memErr
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    hz_state_t        state_r;
    logic [WCW-1:0]   waitCnt_r;
    logic             memErr_r;

    // Handshake state, wait-cycle counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            waitCnt_r <= '0;
            memErr_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access) begin
                        state_r   <= WAIT;
                        waitCnt_r <= '0;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                WAIT: begin
                    if (dmemAck) begin
                        state_r <= DONE;
                    end else if (waitCnt_r == WCW'(TIMEOUT - 1)) begin
                        state_r  <= ERR;
                        memErr_r <= 1'b1;
                    end else begin
                        waitCnt_r <= waitCnt_r + WCW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                ERR: begin
                    state_r  <= ERR;
                    memErr_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign memStall = (access && ((state_r == IDLE) || (state_r == WAIT))) || (state_r == ERR);
    // Gated by reset so a request aborted mid-WAIT drops immediately, without a clock.
    assign dmemReq  = memStall && (state_r != ERR) && reset;
    assign memErr   = memErr_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls, E flush,
// memory-access freeze and a saturating stall-cycle counter.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             memwriteM,
    input  logic             branchD,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             stallE,
    output logic             stallM,
    output logic             flushW,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic lwStall_s;
    logic brStall_s;
    logic memStall_s;
    logic access_s;
    logic frontStall_s;
    logic [CNT_W-1:0] stallCnt_r;

    assign forwardAE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardBE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    assign forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
    assign forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;

    assign lwStall_s = memtoregE && ((rtE == rsD) || (rtE == rtD));
    assign brStall_s = branchD &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
    assign access_s  = memtoregM || memwriteM;

    hazard_mem_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_memFsm (
        .clk      (clk),
        .reset    (reset),
        .access   (access_s),
        .dmemAck  (dmem_ack),
        .memStall (memStall_s),
        .dmemReq  (dmem_req),
        .memErr   (mem_err)
    );

    assign frontStall_s = lwStall_s || brStall_s || memStall_s;
    assign stallF = frontStall_s;
    assign stallD = frontStall_s;
    assign stallE = memStall_s;
    assign stallM = memStall_s;
    assign flushW = memStall_s;
    // While memory freezes the pipe, E must hold its instruction rather than take a bubble.
    assign flushE = (lwStall_s || brStall_s) && !memStall_s;

    // Saturating count of front-end stall cycles; clear takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt_r <= '0;
        end else if (cnt_clr) begin
            stallCnt_r <= '0;
        end else if (frontStall_s && (stallCnt_r != {CNT_W{1'b1}})) begin
            stallCnt_r <= stallCnt_r + CNT_W'(1);
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end

    assign stall_cnt = stallCnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4, CNT_W=4 to reach timeout and saturation).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM;
    logic       branchD, dmem_ack, cnt_clr;
    logic       stallF, stallD, flushE, stallE, stallM, flushW, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       dmem_req, mem_err;
    logic [3:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .branchD(branchD), .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
        .stallF(stallF), .stallD(stallD), .flushE(flushE), .stallE(stallE),
        .stallM(stallM), .flushW(flushW), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0; memwriteM = 1'b0;
        branchD = 1'b0; dmem_ack = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clearInputs();
        #2;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        #10;
        reset = 1'b1;
        tick();

        // forwarding priority and $0 exclusion
        regwriteM = 1'b1; writeregM = 5'd3; regwriteW = 1'b1; writeregW = 5'd3;
        rsE = 5'd3; rtE = 5'd3; rsD = 5'd3;
        #1;
        check("fwdAE_M", 32'(forwardAE), 32'd2);
        check("fwdBE_M", 32'(forwardBE), 32'd2);
        check("fwdAD", 32'(forwardAD), 32'd1);
        regwriteM = 1'b0;
        #1;
        check("fwdAE_W", 32'(forwardAE), 32'd1);
        check("fwdAD_off", 32'(forwardAD), 32'd0);
        regwriteM = 1'b1; rsE = 5'd0; writeregM = 5'd0; rtD = 5'd0;
        #1;
        check("fwdAE_r0", 32'(forwardAE), 32'd0);
        check("fwdBD_r0", 32'(forwardBD), 32'd0);
        check("fwd_nostall", 32'(stallF), 32'd0);
        clearInputs();
        tick();

        // load-use stall
        memtoregE = 1'b1; rtE = 5'd5; rtD = 5'd5;
        #1;
        check("lw_stallF", 32'(stallF), 32'd1);
        check("lw_stallD", 32'(stallD), 32'd1);
        check("lw_flushE", 32'(flushE), 32'd1);
        check("lw_stallE", 32'(stallE), 32'd0);
        tick();
        check("lw_cnt", 32'(stall_cnt), 32'd1);
        memtoregE = 1'b0; memtoregM = 1'b1; writeregM = 5'd5;
        #1;
        check("lwM_flushE", 32'(flushE), 32'd0);
        check("lwM_stallE", 32'(stallE), 32'd1);
        clearInputs();
        tick();
        check("lwM_cnt", 32'(stall_cnt), 32'd1);

        // branch compare stalls
        branchD = 1'b1; rsD = 5'd7; writeregE = 5'd7; regwriteE = 1'b1;
        #1;
        check("br_stallF", 32'(stallF), 32'd1);
        check("br_flushE", 32'(flushE), 32'd1);
        regwriteE = 1'b0; memtoregM = 1'b1; writeregM = 5'd7;
        #1;
        check("brM_stallF", 32'(stallF), 32'd1);
        check("brM_flushE", 32'(flushE), 32'd0);
        clearInputs();
        tick();

        // memory access acked after 3 wait cycles
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(stall_cnt), 32'd0);
        memtoregM = 1'b1; writeregM = 5'd9;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            check($sformatf("acc_req%0d", i), 32'(dmem_req), 32'd1);
            check($sformatf("acc_stall%0d", i), 32'({stallE, stallM, flushW}), 32'd7);
            tick();
        end
        dmem_ack = 1'b0;
        #1;
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_stall", 32'({stallF, stallE, stallM, flushW}), 32'd0);
        check("done_cnt", 32'(stall_cnt), 32'd4);
        memtoregM = 1'b0;
        tick();
        check("idle_cnt", 32'(stall_cnt), 32'd4);

        // timeout into ERR
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        memwriteM = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("to_wait_req", 32'(dmem_req), 32'd1);
        check("to_wait_err", 32'(mem_err), 32'd0);
        tick();
        check("err_flag", 32'(mem_err), 32'd1);
        check("err_req", 32'(dmem_req), 32'd0);
        check("err_stall", 32'({stallF, stallE, stallM, flushW}), 32'hF);
        check("err_cnt", 32'(stall_cnt), 32'd5);
        memwriteM = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("err_hold", 32'({mem_err, stallE}), 32'd3);
        check("cnt_sat", 32'(stall_cnt), 32'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins", 32'(stall_cnt), 32'd0);
        tick();
        check("cnt_after_clr", 32'(stall_cnt), 32'd1);
        memtoregE = 1'b1; rtE = 5'd4; rsD = 5'd4;
        #1;
        check("lw_in_mem_flushE", 32'(flushE), 32'd0);
        check("lw_in_mem_stallF", 32'(stallF), 32'd1);
        clearInputs();
        #1;
        reset = 1'b0;
        #1;
        check("rst_err_clr", 32'(mem_err), 32'd0);
        check("rst_cnt_clr", 32'(stall_cnt), 32'd0);
        check("rst_stallE", 32'(stallE), 32'd0);
        reset = 1'b1;
        tick();

        // reset during WAIT
        memtoregM = 1'b1; writeregM = 5'd2;
        tick();
        tick();
        check("wait_req", 32'(dmem_req), 32'd1);
        check("wait_cnt", 32'(stall_cnt), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_cnt", 32'(stall_cnt), 32'd0);
        check("midrst_stallE", 32'(stallE), 32'd1);
        memtoregM = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        check("post_req", 32'(dmem_req), 32'd0);
        check("post_err", 32'(mem_err), 32'd0);
        check("post_cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time budget exceeded");
    end

endmodule
